multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RISC-V datapath. It drives the ALU's 4-bit operation code and the datapath steering signals. It decodes the instruction register, sequences fetch/decode/execute/memory/writeback, waits on a memory ready handshake, and consumes the ALU zero flag to resolve BEQ. It sits between the instruction register and the datapath muxes and is the producer side of the ALU control interface.

---
 rtl/multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control FSM for a RISC-V datapath. It sequences
// FETCH/DECODE/EXEC/MEM/WB, decodes the instruction register into an ALU
// operation code plus datapath steering signals, waits on a memory ready
// handshake, and uses the ALU zero flag to resolve BEQ.
//
// Configuration macro:
//   ALU_CTRL_MUL_EN  defined   : R-type f3=000/f7=0000001 decodes to MUL (0011)
//                    undefined : that encoding is illegal and traps; alu_ctrl
//                                never takes the value 0011
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   ir         in   instruction register (stable from DECODE onward)
//   alu_zero   in   ALU zero flag (used for BEQ in EXEC only)
//   mem_ready  in   memory access complete this cycle (FETCH/MEM only)
//   alu_ctrl   out  ALU operation code
//   alu_src_a  out  0 = PC, 1 = rs1
//   alu_src_b  out  00 = rs2, 01 = constant 4, 10 = immediate
//   pc_src     out  0 = ALU result, 1 = ALUOut
//   pc_write, ir_write, mem_read, mem_write, reg_write, iord
//              out  datapath strobes; iord = 1 selects the ALUOut address
//   wb_sel     out  0 = ALUOut, 1 = memory data register
//   illegal    out  sticky illegal-instruction flag (held while in TRAP)
//   state      out  current FSM state, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] ir,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic [3:0]      alu_ctrl,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            pc_src,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            iord,
  output logic            wb_sel,
  output logic            illegal,
  output logic [2:0]      state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_AUIPC  = 4'b0100;
  localparam logic [3:0] ALU_BRTGT  = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
`ifdef ALU_CTRL_MUL_EN
  localparam logic [3:0] ALU_MUL    = 4'b0011;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef ALU_CTRL_MUL_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

  logic [2:0] state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  // Register and immediate fields belong to the datapath, not to control.
  logic unused_ir;
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  // ---------------------------------------------------------------------------
  // Instruction decode: class flags, legality and the EXEC-phase ALU op.
  // ---------------------------------------------------------------------------
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_auipc;
  logic       op_legal;
  logic [3:0] exec_op;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_auipc = 1'b0;
    op_legal = 1'b0;
    exec_op  = ALU_ADD;

    case (opcode)
      OP_R: begin
        is_r = 1'b1;
        case (f3)
          3'b000: begin
            if (f7 == F7_BASE) begin
              op_legal = 1'b1;
              exec_op  = ALU_ADD;
            end else if (f7 == F7_ALT) begin
              op_legal = 1'b1;
              exec_op  = ALU_SUB;
            end
`ifdef ALU_CTRL_MUL_EN
            else if (f7 == F7_MULDIV) begin
              op_legal = 1'b1;
              exec_op  = ALU_MUL;
            end
`endif
          end
          3'b111: begin op_legal = (f7 == F7_BASE); exec_op = ALU_AND; end
          3'b110: begin op_legal = (f7 == F7_BASE); exec_op = ALU_OR;  end
          3'b001: begin op_legal = (f7 == F7_BASE); exec_op = ALU_SLL; end
          3'b010: begin op_legal = (f7 == F7_BASE); exec_op = ALU_SLT; end
          default: op_legal = 1'b0;
        endcase
      end
      OP_I: begin
        // f7 overlaps the immediate here, so it plays no part in the decode.
        is_i = 1'b1;
        case (f3)
          3'b000: begin op_legal = 1'b1; exec_op = ALU_ADD; end
          3'b111: begin op_legal = 1'b1; exec_op = ALU_AND; end
          3'b110: begin op_legal = 1'b1; exec_op = ALU_OR;  end
          3'b001: begin op_legal = 1'b1; exec_op = ALU_SLL; end
          3'b010: begin op_legal = 1'b1; exec_op = ALU_SLT; end
          default: op_legal = 1'b0;
        endcase
      end
      OP_LW: begin
        is_lw    = 1'b1;
        op_legal = (f3 == 3'b010);
        exec_op  = ALU_ADD;
      end
      OP_SW: begin
        is_sw    = 1'b1;
        op_legal = (f3 == 3'b010);
        exec_op  = ALU_ADD;
      end
      OP_BEQ: begin
        is_beq   = 1'b1;
        op_legal = (f3 == 3'b000);
        exec_op  = ALU_SUB;
      end
      OP_AUIPC: begin
        is_auipc = 1'b1;
        op_legal = 1'b1;
        exec_op  = ALU_AUIPC;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode. Outputs follow the registered state; the
  // only input-dependent strobes are the FETCH handshake and the BEQ PC write.
  // Because the state flop clears asynchronously, every strobe drops to 0 as
  // soon as reset_n falls.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    alu_ctrl  = ALU_AND;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    iord      = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // PC has already advanced by 4, so this forms (PC-4)+imm in ALUOut.
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_BRTGT;
        state_d   = op_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        alu_ctrl = exec_op;
        if (!op_legal) begin
          alu_ctrl = ALU_AND;
          state_d  = S_TRAP;
        end else if (is_r) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b00;
          state_d   = S_WB;
        end else if (is_i) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_MEM;
        end else if (is_beq) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b00;
          pc_src    = 1'b1;
          pc_write  = alu_zero;
          state_d   = S_FETCH;
        end else if (is_auipc) begin
          alu_src_a = 1'b0;
          alu_src_b = 2'b10;
          state_d   = S_WB;
        end else begin
          state_d = S_TRAP;
        end
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_lw;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end

      default: state_d = S_TRAP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed self-checking bench for multicycle_ctrl. Stimulus is a linear
// sequence of instruction walks; outputs are sampled on the falling edge,
// inputs are changed on the falling edge as well. Expected values are
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] ir;
  logic        alu_zero;
  logic        mem_ready;
  logic [3:0]  alu_ctrl;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_src;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        iord;
  logic        wb_sel;
  logic        illegal;
  logic [2:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  multicycle_ctrl #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ir        (ir),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .pc_src    (pc_src),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .iord      (iord),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full clock: rising edge updates the DUT, falling edge is the sample
  // and drive point.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // All write strobes together, packed for one-shot checks.
  function automatic logic [5:0] strobes();
    return {pc_write, ir_write, mem_read, mem_write, reg_write, iord};
  endfunction

  initial begin
    reset_n   = 1'b0;
    ir        = 32'h002081B3;   // add x3,x1,x2
    alu_zero  = 1'b0;
    mem_ready = 1'b1;

    // ---------------- reset state, no clock edge needed ----------------
    #2;
    check("rst_state",   state,    3'd0);
    check("rst_illegal", illegal,  1'b0);
    check("rst_strobes", strobes(), 6'b0);
    check("rst_aluctrl", alu_ctrl, 4'b0000);

    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- ADD: 0,1,2,3,5,1 ----------------
    tick();
    check("add_fetch_state", state,     3'd1);
    check("add_fetch_strb",  strobes(), 6'b111000);
    check("add_fetch_srcb",  alu_src_b, 2'b01);
    check("add_fetch_alu",   alu_ctrl,  4'b0010);
    check("add_fetch_srca",  alu_src_a, 1'b0);
    tick();
    check("add_dec_state",   state,     3'd2);
    check("add_dec_alu",     alu_ctrl,  4'b0110);
    check("add_dec_srcb",    alu_src_b, 2'b10);
    tick();
    check("add_exec_state",  state,     3'd3);
    check("add_exec_alu",    alu_ctrl,  4'b0010);
    check("add_exec_srca",   alu_src_a, 1'b1);
    check("add_exec_srcb",   alu_src_b, 2'b00);
    tick();
    check("add_wb_state",    state,     3'd5);
    check("add_wb_regwr",    reg_write, 1'b1);
    check("add_wb_wbsel",    wb_sel,    1'b0);
    tick();
    check("add_next_fetch",  state,     3'd1);

    // ---------------- SUB ----------------
    ir = 32'h402081B3;
    tick(); tick();
    check("sub_exec_state",  state,    3'd3);
    check("sub_exec_alu",    alu_ctrl, 4'b0101);
    tick(); tick();
    check("sub_next_fetch",  state,    3'd1);

    // ---------------- SLTI ----------------
    ir = 32'h0050A193;
    tick(); tick();
    check("slti_exec_alu",   alu_ctrl,  4'b1000);
    check("slti_exec_srcb",  alu_src_b, 2'b10);
    tick();
    check("slti_wb_state",   state,     3'd5);
    tick();
    check("slti_next_fetch", state,     3'd1);

    // ---------------- LW with two wait cycles in MEM (7 cycles) ----------------
    ir = 32'h0000A183;
    tick();
    check("lw_dec_state",    state,    3'd2);
    tick();
    check("lw_exec_state",   state,    3'd3);
    check("lw_exec_alu",     alu_ctrl, 4'b0010);
    mem_ready = 1'b0;
    tick();
    check("lw_mem1_state",   state,     3'd4);
    check("lw_mem1_strb",    strobes(), 6'b001001);
    tick();
    check("lw_mem2_state",   state,     3'd4);
    check("lw_mem2_strb",    strobes(), 6'b001001);
    tick();
    check("lw_mem3_state",   state,     3'd4);
    check("lw_mem3_strb",    strobes(), 6'b001001);
    mem_ready = 1'b1;
    tick();
    check("lw_wb_state",     state,     3'd5);
    check("lw_wb_wbsel",     wb_sel,    1'b1);
    check("lw_wb_regwr",     reg_write, 1'b1);
    tick();
    check("lw_next_fetch",   state,     3'd1);

    // ---------------- FETCH wait: outputs held, no IR/PC write ----------------
    ir = 32'h0020A023;           // sw x2,0(x1)
    mem_ready = 1'b0;
    tick();
    check("fwait_state",     state,     3'd1);
    check("fwait_strb",      strobes(), 6'b001000);
    mem_ready = 1'b1;
    tick();
    check("sw_dec_state",    state,     3'd2);
    tick();
    check("sw_exec_state",   state,     3'd3);
    tick();
    check("sw_mem_state",    state,     3'd4);
    check("sw_mem_strb",     strobes(), 6'b000101);
    tick();
    check("sw_next_fetch",   state,     3'd1);

    // ---------------- BEQ taken ----------------
    ir = 32'h00208463;
    alu_zero = 1'b1;
    tick();
    check("beqt_dec_alu",    alu_ctrl, 4'b0110);
    tick();
    check("beqt_exec_alu",   alu_ctrl, 4'b0101);
    check("beqt_exec_pcwr",  pc_write, 1'b1);
    check("beqt_exec_pcsrc", pc_src,   1'b1);
    tick();
    check("beqt_next_fetch", state,    3'd1);

    // ---------------- BEQ not taken ----------------
    alu_zero = 1'b0;
    tick();
    check("beqn_dec_alu",    alu_ctrl, 4'b0110);
    tick();
    check("beqn_exec_alu",   alu_ctrl, 4'b0101);
    check("beqn_exec_pcwr",  pc_write, 1'b0);
    tick();
    check("beqn_next_fetch", state,    3'd1);

    // ---------------- MUL ----------------
    ir = 32'h022081B3;
    tick();
    check("mul_dec_state",   state,    3'd2);
    tick();
`ifdef ALU_CTRL_MUL_EN
    check("mul_exec_state",  state,    3'd3);
    check("mul_exec_alu",    alu_ctrl, 4'b0011);
    tick();
    check("mul_wb_state",    state,    3'd5);
    tick();
    check("mul_next_fetch",  state,    3'd1);
`else
    check("mul_trap_state",  state,     3'd7);
    check("mul_trap_ill",    illegal,   1'b1);
    check("mul_trap_strb",   strobes(), 6'b0);
    tick(); tick();
    check("mul_trap_hold",   state,     3'd7);
    check("mul_trap_stick",  illegal,   1'b1);
    reset_n = 1'b0;
    #1;
    check("mul_rst_state",   state,     3'd0);
    check("mul_rst_ill",     illegal,   1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("mul_rel_fetch",   state,     3'd1);
`endif

    // ---------------- reset mid-FETCH drops write strobes at once ----------------
    check("midrst_pre_pcwr", pc_write, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_strb",     strobes(), 6'b0);
    check("midrst_state",    state,     3'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- all-ones instruction traps after DECODE ----------------
    ir = 32'hFFFFFFFF;
    tick();
    check("ill_fetch_state", state,   3'd1);
    tick();
    check("ill_dec_state",   state,   3'd2);
    tick();
    check("ill_trap_state",  state,   3'd7);
    check("ill_trap_flag",   illegal, 1'b1);
    check("ill_trap_alu",    alu_ctrl, 4'b0000);
    tick();
    check("ill_trap_hold",   state,   3'd7);
    #1;
    reset_n = 1'b0;
    #1;
    check("ill_rst_state",   state,   3'd0);
    check("ill_rst_flag",    illegal, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
